// File: rtl/instr_fetch_if.sv
// Program-memory read bus between the fetch sequencer and program ROM/RAM.
//   mem_req  - read request (master -> slave)
//   mem_addr - read address (master -> slave)
//   mem_ack  - read data valid this cycle, may coincide with mem_req (slave -> master)
//   mem_data - read data byte (slave -> master)
interface instr_fetch_if #(
   parameter int unsigned ADDR_W = 8
) ();
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [7:0]        mem_data;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_data
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_data
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads the opcode byte at pc and the operand byte at pc+1 over
// the program-memory bus, presents them with instr_valid until the execute stage reports
// exec_done, then advances pc by 2 or redirects it to jump_target.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   stall             - holds off starting a new fetch (only looked at while idle)
//   mem               - program-memory read bus (master side)
//   opcode, w         - fetched opcode and operand byte
//   instr_valid       - opcode/w/pc hold a complete instruction
//   pc                - address of the current instruction's opcode byte
//   exec_done         - execute stage finished with the current instruction
//   jump_taken        - redirect request, sampled with exec_done
//   jump_target       - redirect address, sampled with exec_done
//   fetch_error       - one-cycle pulse when a byte read times out
//
// Build option: define IFETCH_TIMEOUT_EN to abandon a byte read after TIMEOUT_CYCLES cycles
// without mem_ack; otherwise a read waits forever and fetch_error is tied low.
module instr_fetch #(
   parameter int unsigned       ADDR_W         = 8,
   parameter logic [ADDR_W-1:0] RESET_VECTOR   = '0,
   parameter int unsigned       TIMEOUT_CYCLES = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   instr_fetch_if.master     mem,
   output logic [7:0]        opcode,
   output logic [7:0]        w,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] pc,
   input  logic              exec_done,
   input  logic              jump_taken,
   input  logic [ADDR_W-1:0] jump_target,
   output logic              fetch_error
);

   typedef enum logic [1:0] {StIdle, StFetchOp, StFetchW, StIssue} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [7:0]        opcode_q, opcode_d;
   logic [7:0]        w_q, w_d;
   logic              timeout_hit;

`ifdef IFETCH_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            fetch_error_q;

   // Counts ack-less cycles of the byte currently being read; held at zero outside the fetch
   // states so every entry into FETCH_OP starts from a cleared count.
   always_comb begin
      cnt_d       = cnt_q;
      timeout_hit = 1'b0;
      unique case (state_q)
         StFetchOp, StFetchW: begin
            if (mem.mem_ack) begin
               cnt_d = '0;
            end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
               // An ack in this same cycle takes the branch above instead.
               timeout_hit = 1'b1;
               cnt_d       = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: cnt_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q         <= '0;
         fetch_error_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         fetch_error_q <= timeout_hit;
      end
   end

   assign fetch_error = fetch_error_q;
`else
   logic unused_timeout_cycles;

   assign timeout_hit           = 1'b0;
   assign fetch_error           = 1'b0;
   assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      opcode_d     = opcode_q;
      w_d          = w_q;
      mem.mem_req  = 1'b0;
      mem.mem_addr = pc_q;
      unique case (state_q)
         StIdle: begin
            if (!stall) begin
               state_d = StFetchOp;
            end
         end
         StFetchOp: begin
            mem.mem_req = 1'b1;
            if (mem.mem_ack) begin
               opcode_d = mem.mem_data;
               state_d  = StFetchW;
            end else if (timeout_hit) begin
               state_d = StIdle;
            end
         end
         StFetchW: begin
            mem.mem_req  = 1'b1;
            mem.mem_addr = pc_q + ADDR_W'(1);
            if (mem.mem_ack) begin
               w_d     = mem.mem_data;
               state_d = StIssue;
            end else if (timeout_hit) begin
               // Retry restarts from the opcode byte; the opcode register is refilled then.
               state_d = StIdle;
            end
         end
         StIssue: begin
            if (exec_done) begin
               pc_d    = jump_taken ? jump_target : pc_q + ADDR_W'(2);
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         pc_q     <= RESET_VECTOR;
         opcode_q <= 8'h00;
         w_q      <= 8'h00;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         opcode_q <= opcode_d;
         w_q      <= w_d;
      end
   end

   assign opcode      = opcode_q;
   assign w           = w_q;
   assign pc          = pc_q;
   assign instr_valid = (state_q == StIssue);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: program memory with configurable ack latency, directed latency and
// corner-case sequences, then a randomized run checked against an instruction-level model
// (opcode = mem[pc], w = mem[pc+1], pc advances by 2 or jumps).
module tb_instr_fetch;
   localparam int AW = 8;

   logic          clk;
   logic          rst;
   logic          stall;
   logic          exec_done;
   logic          jump_taken;
   logic [AW-1:0] jump_target;
   logic [7:0]    opcode;
   logic [7:0]    w;
   logic          instr_valid;
   logic [AW-1:0] pc;
   logic          fetch_error;

   instr_fetch_if #(.ADDR_W(AW)) bus ();

   instr_fetch #(
      .ADDR_W        (AW),
      .RESET_VECTOR  (8'h00),
      .TIMEOUT_CYCLES(15)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .mem        (bus),
      .opcode     (opcode),
      .w          (w),
      .instr_valid(instr_valid),
      .pc         (pc),
      .exec_done  (exec_done),
      .jump_taken (jump_taken),
      .jump_target(jump_target),
      .fetch_error(fetch_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Program memory and responder controls
   logic [7:0] mem [256];
   bit         rand_mode   = 1'b0;
   int         fixed_delay = 0;
   bit         late_ack    = 1'b0;
   int         acked[$];

   // Reference model state
   int m_pc     = 0;
   bit err_seen = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Responder: decides ack/data at the falling edge so the DUT samples them at the next
   // rising edge; a zero delay acks in the same cycle as the request.
   initial begin
      int  wait_cnt  = 0;
      int  cur_delay = 0;
      bit  prev_rst  = 1'b1;
      bit  prev_req  = 1'b0;
      bit  prev_ack  = 1'b0;
      logic [AW-1:0] prev_addr = '0;
      bus.mem_ack  = 1'b0;
      bus.mem_data = 8'h00;
      forever begin
         @(negedge clk);
         if (!prev_rst && prev_req && !prev_ack) begin
            check("req_hold", {31'd0, bus.mem_req}, 32'd1);
            check("addr_hold", {24'd0, bus.mem_addr}, {24'd0, prev_addr});
         end
         if (bus.mem_req) begin
            if (wait_cnt >= cur_delay) begin
               bus.mem_ack  = 1'b1;
               bus.mem_data = mem[bus.mem_addr];
               acked.push_back(int'(bus.mem_addr));
               wait_cnt     = 0;
               cur_delay    = rand_mode ? $urandom_range(0, 3) : fixed_delay;
            end else begin
               bus.mem_ack  = 1'b0;
               bus.mem_data = 8'($urandom);
               wait_cnt++;
            end
         end else begin
            wait_cnt     = 0;
            cur_delay    = rand_mode ? $urandom_range(0, 3) : fixed_delay;
            bus.mem_ack  = late_ack || (rand_mode && ($urandom_range(0, 3) == 0));
            bus.mem_data = late_ack ? 8'hEE : 8'($urandom);
         end
         prev_rst  = rst;
         prev_req  = bus.mem_req;
         prev_ack  = bus.mem_ack;
         prev_addr = bus.mem_addr;
      end
   end

   // Completes the current instruction and updates the model pc.
   task automatic do_exec(input bit jmp, input int target);
      acked.delete();
      exec_done   = 1'b1;
      jump_taken  = jmp;
      jump_target = AW'(target);
      tick();
      exec_done   = 1'b0;
      jump_taken  = 1'($urandom);
      jump_target = AW'($urandom);
      m_pc = jmp ? (target % 256) : ((m_pc + 2) % 256);
      check("valid_drop", {31'd0, instr_valid}, 32'd0);
   endtask

   // Ticks until instr_valid, optionally driving noise on inputs that must be ignored.
   task automatic wait_valid(output int n, input bit noise);
      n = 0;
      while (!instr_valid && n < 200) begin
         if (noise) begin
            stall       = ($urandom_range(0, 3) == 0);
            exec_done   = 1'($urandom);
            jump_taken  = 1'($urandom);
            jump_target = AW'($urandom);
         end
         tick();
         n++;
         err_seen = err_seen | fetch_error;
      end
      exec_done = 1'b0;
      stall     = 1'b0;
      check("valid_seen", {31'd0, instr_valid}, 32'd1);
   endtask

   task automatic check_instr();
      check("opcode", {24'd0, opcode}, {24'd0, mem[m_pc]});
      check("w", {24'd0, w}, {24'd0, mem[(m_pc + 1) % 256]});
      check("pc", {24'd0, pc}, 32'(m_pc));
      check("ack_count", 32'(acked.size()), 32'd2);
      if (acked.size() == 2) begin
         check("addr_op", 32'(acked[0]), 32'(m_pc));
         check("addr_w", 32'(acked[1]), 32'((m_pc + 1) % 256));
      end
   endtask

   initial begin
      int n;
      int k;
      rst         = 1'b1;
      stall       = 1'b0;
      exec_done   = 1'b0;
      jump_taken  = 1'b0;
      jump_target = '0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h12;
      mem[1] = 8'h34;

      repeat (3) tick();
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_opcode", {24'd0, opcode}, 32'h00);
      check("rst_w", {24'd0, w}, 32'h00);
      check("rst_pc", {24'd0, pc}, 32'h00);
      check("rst_req", {31'd0, bus.mem_req}, 32'd0);
      check("rst_addr", {24'd0, bus.mem_addr}, 32'h00);
      check("rst_err", {31'd0, fetch_error}, 32'd0);

      // Zero-wait fetch out of reset
      acked.delete();
      rst = 1'b0;
      tick();
      check("c1_req", {31'd0, bus.mem_req}, 32'd1);
      check("c1_addr", {24'd0, bus.mem_addr}, 32'h00);
      check("c1_valid", {31'd0, instr_valid}, 32'd0);
      tick();
      check("c2_req", {31'd0, bus.mem_req}, 32'd1);
      check("c2_addr", {24'd0, bus.mem_addr}, 32'h01);
      check("c2_valid", {31'd0, instr_valid}, 32'd0);
      tick();
      check("c3_valid", {31'd0, instr_valid}, 32'd1);
      check("c3_opcode", {24'd0, opcode}, 32'h12);
      check("c3_w", {24'd0, w}, 32'h34);
      m_pc = 0;
      check_instr();

      // Sequential advance, then a jump
      do_exec(1'b0, 0);
      wait_valid(n, 1'b0);
      check("seq_lat", 32'(n), 32'd3);
      check("seq_pc", {24'd0, pc}, 32'h02);
      check_instr();
      do_exec(1'b1, 8'h40);
      wait_valid(n, 1'b0);
      check("jmp_lat", 32'(n), 32'd3);
      check_instr();

      // Four wait states per byte
      fixed_delay = 4;
      do_exec(1'b0, 0);
      wait_valid(n, 1'b0);
      check("slow_lat", 32'(n), 32'd11);
      check_instr();
      fixed_delay = 0;

      // Wrap-around at the top of the address space
      mem[8'hFF] = 8'hA5;
      mem[8'h00] = 8'h5A;
      do_exec(1'b1, 8'hFF);
      wait_valid(n, 1'b0);
      check("wrap_opcode", {24'd0, opcode}, 32'hA5);
      check("wrap_w", {24'd0, w}, 32'h5A);
      check_instr();
      do_exec(1'b0, 0);
      wait_valid(n, 1'b0);
      check("wrap_next_pc", {24'd0, pc}, 32'h01);
      check_instr();

      // Stall held in idle
      stall = 1'b1;
      do_exec(1'b0, 0);
      for (int i = 0; i < 5; i++) begin
         check("stall_req", {31'd0, bus.mem_req}, 32'd0);
         tick();
      end
      stall = 1'b0;
      wait_valid(n, 1'b0);
      check("stall_lat", 32'(n), 32'd3);
      check_instr();

      // Reset while reading the operand byte, then a late ack while idle
      fixed_delay = 4;
      do_exec(1'b0, 0);
      k = 0;
      while (!(bus.mem_req && bus.mem_addr == AW'(m_pc + 1)) && k < 50) begin
         tick();
         k++;
      end
      check("reach_fetch_w", {31'd0, k < 50}, 32'd1);
      rst = 1'b1;
      tick();
      rst   = 1'b0;
      stall = 1'b1;
      m_pc  = 0;
      check("mrst_req", {31'd0, bus.mem_req}, 32'd0);
      check("mrst_pc", {24'd0, pc}, 32'h00);
      check("mrst_valid", {31'd0, instr_valid}, 32'd0);
      late_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("late_valid", {31'd0, instr_valid}, 32'd0);
         check("late_opcode", {24'd0, opcode}, 32'h00);
         check("late_req", {31'd0, bus.mem_req}, 32'd0);
      end
      late_ack    = 1'b0;
      fixed_delay = 0;
      tick();
      acked.delete();
      stall = 1'b0;
      wait_valid(n, 1'b0);
      check("post_rst_lat", 32'(n), 32'd3);
      check_instr();

`ifdef IFETCH_TIMEOUT_EN
      // No ack: error pulse after 15 waiting cycles, then retry at the same pc
      fixed_delay = 1000;
      do_exec(1'b0, 0);
      n = 0;
      while (!fetch_error && n < 100) begin
         tick();
         n++;
      end
      check("to_lat", 32'(n), 32'd16);
      check("to_req_drop", {31'd0, bus.mem_req}, 32'd0);
      check("to_valid", {31'd0, instr_valid}, 32'd0);
      check("to_pc", {24'd0, pc}, 32'(m_pc));
      fixed_delay = 14;
      tick();
      check("to_pulse", {31'd0, fetch_error}, 32'd0);
      check("retry_req", {31'd0, bus.mem_req}, 32'd1);
      check("retry_addr", {24'd0, bus.mem_addr}, 32'(m_pc));
      err_seen = 1'b0;
      wait_valid(n, 1'b0);
      check("edge_ack_lat", 32'(n), 32'd30);
      check("edge_ack_err", {31'd0, err_seen}, 32'd0);
      check_instr();
      fixed_delay = 0;
`endif

      // Randomized run against the instruction-level model
      rand_mode = 1'b1;
      err_seen  = 1'b0;
      for (int i = 0; i < 150; i++) begin
         bit jmp;
         jmp = ($urandom_range(0, 3) == 0);
         do_exec(jmp, int'($urandom_range(0, 255)));
         wait_valid(n, 1'b1);
         check_instr();
         k = int'($urandom_range(0, 3));
         for (int j = 0; j < k; j++) begin
            tick();
            check("hold_valid", {31'd0, instr_valid}, 32'd1);
            check("hold_opcode", {24'd0, opcode}, {24'd0, mem[m_pc]});
            check("hold_w", {24'd0, w}, {24'd0, mem[(m_pc + 1) % 256]});
         end
      end
      check("no_fetch_error", {31'd0, err_seen}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch sequencer that produces the opcode and operand byte (w) consumed by the microcode decoder. It reads two consecutive bytes from program memory over a req/ack handshake and holds them stable with instr_valid. It then waits for the execute stage to signal completion, and advances the PC sequentially or redirects it to a jump target. It sits between program ROM/RAM and the ucode decoder/execute datapath.

Parameters:
ADDR_W, 8, program address width; all PC arithmetic is modulo 2^ADDR_W
RESET_VECTOR, 0, PC value loaded on reset
TIMEOUT_CYCLES, 15, max wait-for-ack cycles per byte (used only with IFETCH_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
stall  input  1  hold off starting a new fetch while high
mem_req  output  1  memory read request
mem_addr  output  ADDR_W  memory read address
mem_ack  input  1  read data valid this cycle; may be asserted in the same cycle as mem_req
mem_data  input  8  read data, sampled when mem_ack=1
opcode  output  8  fetched opcode to decoder
w  output  8  fetched operand byte to decoder
instr_valid  output  1  opcode/w/pc hold a complete instruction
pc  output  ADDR_W  address of the current instruction's opcode byte
exec_done  input  1  execute stage has finished with the current instruction
jump_taken  input  1  redirect request, sampled with exec_done
jump_target  input  ADDR_W  redirect address, sampled with exec_done
fetch_error  output  1  one-cycle pulse on ack timeout (constant 0 without the feature)

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, pc=RESET_VECTOR, opcode=0x00, w=0x00, instr_valid=0, fetch_error=0. rst overrides all other inputs.
- Outputs decoded from state: mem_req=1 only in FETCH_OP/FETCH_W. mem_addr=pc+1 in FETCH_W, otherwise pc (RESET_VECTOR out of reset).
- IDLE: mem_req=0. If stall=0, go to FETCH_OP next cycle; otherwise remain.
- FETCH_OP: mem_req=1, mem_addr=pc. On mem_ack: opcode<=mem_data, go to FETCH_W. mem_req stays high across the transition; the address changes to pc+1.
- FETCH_W: mem_req=1, mem_addr=pc+1. On mem_ack: w<=mem_data, go to ISSUE.
- ISSUE: instr_valid=1 (registered, high every cycle in ISSUE). opcode/w/pc stay stable.
  - On exec_done: pc<=jump_taken ? jump_target : pc+2, then go to IDLE. instr_valid is 0 from the next cycle.
- Latency with zero-wait memory (ack in the same cycle as req): IDLE, FETCH_OP, FETCH_W, then ISSUE. instr_valid is high 3 cycles after leaving reset; each later instruction arrives 3 cycles after exec_done.
- mem_data is sampled only in the mem_ack cycle. mem_req is held and mem_addr stays stable until ack arrives.
- stall is checked only in IDLE. Once FETCH_OP is entered, the fetch runs to completion regardless of stall.
- Ignored inputs:
  - mem_ack in IDLE or ISSUE, including a late ack after a mid-transaction reset.
  - exec_done outside ISSUE.
  - jump_taken and jump_target without exec_done.
- Wrap-around: pc=2^ADDR_W-1 fetches its w from address 0; the sequential next pc is 1. Odd jump targets are legal.
- Reset during FETCH_OP/FETCH_W: mem_req is 0 the cycle after the reset edge, and the partially fetched instruction is discarded.

Optional Feature:
IFETCH_TIMEOUT_EN
- Defined:
  - A counter clears on entry to FETCH_OP and on each ack, and counts cycles in FETCH states without ack.
  - When it reaches TIMEOUT_CYCLES without ack: fetch_error pulses 1 for one cycle, state returns to IDLE, pc is unchanged and opcode/w are not updated. The fetch is retried from the opcode byte.
  - An ack in the same cycle as expiry wins (no error).
- Undefined: no counter; a fetch waits for ack indefinitely; fetch_error is tied 0.

Test Plan:
- Zero-wait memory, mem[0]=0x12, mem[1]=0x34; release reset -> instr_valid=1 at cycle 3, opcode=0x12, w=0x34, pc=0x00; mem_addr sequence 0x00, 0x01.
- exec_done=1, jump_taken=0 at pc=0x00 -> next fetch at 0x02/0x03, instr_valid low for exactly 3 cycles. Then exec_done=1, jump_taken=1, jump_target=0x40 -> fetch addresses 0x40, 0x41, pc=0x40.
- Ack delayed 4 cycles per byte -> mem_req continuously high, mem_addr stable until each ack; instr_valid after 1+5+5 cycles.
- Jump to 0xFF, mem[0xFF]=0xA5, mem[0x00]=0x5A -> opcode=0xA5, w=0x5A; sequential next pc=0x01.
- stall=1 in IDLE for 5 cycles -> mem_req=0 throughout. Assert rst in FETCH_W -> pc=RESET_VECTOR, instr_valid=0, and a late ack is ignored.
- With IFETCH_TIMEOUT_EN, TIMEOUT_CYCLES=15 and no ack -> fetch_error pulses 1 cycle, mem_req drops, then retry at the same pc; an ack in the expiry cycle gives no error.
